// File: rtl/compressor_pkg.sv
// Shared constants, FSM encoding and probability adaptation
// for the byte-stream compressor.
package compressor_pkg;

  localparam int PROB_BITS   = 12;
  localparam int ADAPT_SHIFT = 4;
  localparam int N_CODERS    = 8;
  localparam int TABLE_DEPTH = 256;

  typedef logic [PROB_BITS-1:0] prob_t;

  localparam prob_t PROB_INIT = prob_t'(2048);
  localparam logic [PROB_BITS:0] PROB_ONE = 13'h1000;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CODE,
    S_SHIFT,
    S_FLUSH,
    S_DONE
  } state_t;

  function automatic prob_t prob_adapt(
    input prob_t p,
    input logic  b
  );
    logic [PROB_BITS:0] diff;
    logic [PROB_BITS:0] inc;
    diff = PROB_ONE - {1'b0, p};
    inc  = diff >> ADAPT_SHIFT;
    if (b)
      return p + inc[PROB_BITS-1:0];
    else
      return p - (p >> ADAPT_SHIFT);
  endfunction

endpackage

// File: rtl/arith_coder_step.sv
// One binary arithmetic coding step: split the interval,
// keep the half selected by the bit, flag a settled top byte.
module arith_coder_step
  import compressor_pkg::*;
(
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  prob_t       p,
  input  logic        bit_in,
  output logic [31:0] x1_nxt,
  output logic [31:0] x2_nxt,
  output logic        emit
);

  logic [31:0] span;
  logic [31:0] xmid;

  always_comb begin
    span   = (x2 - x1) >> PROB_BITS;
    xmid   = x1 + span * {20'd0, p};
    x1_nxt = x1;
    x2_nxt = x2;
    if (bit_in)
      x2_nxt = xmid;
    else
      x1_nxt = xmid + 32'd1;
    emit = (x1_nxt[31:24] == x2_nxt[31:24]);
  end

endmodule

// File: rtl/compressor.sv
// Order-0 bit-context model feeding eight arithmetic coders,
// one per bit position, with per-coder tagged output bytes.
module compressor
  import compressor_pkg::*;
(
  input  logic       model_clk,
  input  logic       model_rst,
  input  logic       model_in_valid,
  output logic       model_in_ready,
  input  logic [7:0] model_in_bits_byte,
  input  logic       model_in_bits_last,
  output logic       model_status_initDone,
  output logic       coder_out_valid,
  input  logic       coder_out_ready,
  output logic [7:0] coder_out_bits_idx,
  output logic [7:0] coder_out_bits_byte,
  output logic       coder_out_bits_last
);

  prob_t       tbl [TABLE_DEPTH];
  logic [31:0] x1  [N_CODERS];
  logic [31:0] x2  [N_CODERS];

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  init_cnt;
  logic        init_done;
  logic [7:0]  byte_r;
  logic        last_r;
  logic [2:0]  bit_k;
  logic [7:0]  ctx;
  logic [2:0]  fl_k;

  logic        cur_bit;
  prob_t       p_cur;
  logic [31:0] x1_c;
  logic [31:0] x2_c;
  logic [31:0] x1_n;
  logic [31:0] x2_n;
  logic        emit;
  logic        more;
  logic        last_bit;
  state_t      adv_state;

  assign cur_bit  = byte_r[3'd7 - bit_k];
  assign p_cur    = tbl[ctx];
  assign x1_c     = x1[bit_k];
  assign x2_c     = x2[bit_k];
  assign more     = (x1_c[23:16] == x2_c[23:16]);
  assign last_bit = (bit_k == 3'd7);

  assign model_status_initDone = init_done;

  arith_coder_step u_step (
    .x1     (x1_c),
    .x2     (x2_c),
    .p      (p_cur),
    .bit_in (cur_bit),
    .x1_nxt (x1_n),
    .x2_nxt (x2_n),
    .emit   (emit)
  );

  always_comb begin
    adv_state = S_CODE;
    if (last_bit)
      adv_state = last_r ? S_FLUSH : S_IDLE;
  end

  always_ff @(posedge model_clk) begin
    if (model_rst)
      state <= S_INIT;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt           = state;
    model_in_ready      = 1'b0;
    coder_out_valid     = 1'b0;
    coder_out_bits_idx  = 8'd0;
    coder_out_bits_byte = 8'd0;
    coder_out_bits_last = 1'b0;
    unique case (state)
      S_INIT: begin
        if (init_cnt == 8'hFF)
          state_nxt = S_IDLE;
      end
      S_IDLE: begin
        model_in_ready = init_done;
        if (model_in_valid && init_done)
          state_nxt = S_CODE;
      end
      S_CODE: begin
        if (emit)
          state_nxt = S_SHIFT;
        else
          state_nxt = adv_state;
      end
      S_SHIFT: begin
        coder_out_valid     = 1'b1;
        coder_out_bits_idx  = {5'd0, bit_k};
        coder_out_bits_byte = x2_c[31:24];
        if (coder_out_ready && !more)
          state_nxt = adv_state;
      end
      S_FLUSH: begin
        coder_out_valid     = 1'b1;
        coder_out_bits_idx  = {5'd0, fl_k};
        coder_out_bits_byte = x1[fl_k][31:24];
        coder_out_bits_last = (fl_k == 3'd7);
        if (coder_out_ready && fl_k == 3'd7)
          state_nxt = S_DONE;
      end
      S_DONE: ;
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge model_clk) begin
    if (model_rst) begin
      init_cnt  <= 8'd0;
      init_done <= 1'b0;
      byte_r    <= 8'd0;
      last_r    <= 1'b0;
      bit_k     <= 3'd0;
      ctx       <= 8'd1;
      fl_k      <= 3'd0;
      for (int i = 0; i < N_CODERS; i++) begin
        x1[i] <= 32'd0;
        x2[i] <= 32'hFFFF_FFFF;
      end
    end else begin
      case (state)
        S_INIT: begin
          init_cnt <= init_cnt + 8'd1;
          if (init_cnt == 8'hFF)
            init_done <= 1'b1;
        end
        S_IDLE: begin
          if (model_in_valid && init_done) begin
            byte_r <= model_in_bits_byte;
            last_r <= model_in_bits_last;
            bit_k  <= 3'd0;
            ctx    <= 8'd1;
          end
        end
        S_CODE: begin
          x1[bit_k] <= x1_n;
          x2[bit_k] <= x2_n;
          ctx       <= {ctx[6:0], cur_bit};
          if (!emit)
            bit_k <= bit_k + 3'd1;
        end
        S_SHIFT: begin
          if (coder_out_ready) begin
            x1[bit_k] <= {x1_c[23:0], 8'h00};
            x2[bit_k] <= {x2_c[23:0], 8'hFF};
            if (!more)
              bit_k <= bit_k + 3'd1;
          end
        end
        S_FLUSH: begin
          if (coder_out_ready)
            fl_k <= fl_k + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // table has no reset: INIT rewrites every entry
  always_ff @(posedge model_clk) begin
    if (!model_rst) begin
      if (state == S_INIT)
        tbl[init_cnt] <= PROB_INIT;
      else if (state == S_CODE)
        tbl[ctx] <= prob_adapt(p_cur, cur_bit);
    end
  end

endmodule

// File: tb/tb_compressor.sv
// Bench for compressor: directed streams plus random traffic
// against an arithmetic reference model.
module tb_compressor;

  logic       model_clk = 1'b0;
  logic       model_rst = 1'b1;
  logic       model_in_valid = 1'b0;
  logic       model_in_ready;
  logic [7:0] model_in_bits_byte = 8'd0;
  logic       model_in_bits_last = 1'b0;
  logic       model_status_initDone;
  logic       coder_out_valid;
  logic       coder_out_ready = 1'b1;
  logic [7:0] coder_out_bits_idx;
  logic [7:0] coder_out_bits_byte;
  logic       coder_out_bits_last;

  always #5 model_clk = ~model_clk;

  compressor dut (
    .model_clk             (model_clk),
    .model_rst             (model_rst),
    .model_in_valid        (model_in_valid),
    .model_in_ready        (model_in_ready),
    .model_in_bits_byte    (model_in_bits_byte),
    .model_in_bits_last    (model_in_bits_last),
    .model_status_initDone (model_status_initDone),
    .coder_out_valid       (coder_out_valid),
    .coder_out_ready       (coder_out_ready),
    .coder_out_bits_idx    (coder_out_bits_idx),
    .coder_out_bits_byte   (coder_out_bits_byte),
    .coder_out_bits_last   (coder_out_bits_last)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  stim_b [$];
  bit          stim_l [$];
  logic [16:0] exp_q  [$];
  logic [16:0] obs_q  [$];
  logic [16:0] ref_q  [$];
  int          acc_cyc[$];

  int unsigned     mp  [256];
  longint unsigned mx1 [8];
  longint unsigned mx2 [8];

  localparam longint unsigned TOP = 64'd16777216;
  localparam longint unsigned MOD = 64'h1_0000_0000;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge model_clk);
    #1;
  endtask

  function automatic logic [16:0] pk(input int k,
                                     input longint unsigned b,
                                     input bit l);
    logic [7:0] kk;
    logic [7:0] bb;
    kk = 8'(k);
    bb = 8'(b);
    return {kk, bb, l};
  endfunction

  function automatic logic [19:0] out_vec();
    return {model_status_initDone, model_in_ready,
            coder_out_valid, coder_out_bits_idx,
            coder_out_bits_byte, coder_out_bits_last};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mp[i] = 2048;
    for (int k = 0; k < 8; k++) begin
      mx1[k] = 0;
      mx2[k] = 64'hFFFF_FFFF;
    end
  endtask

  // interval split, probability update and byte emission
  // written directly from the arithmetic rules
  task automatic model_byte(input logic [7:0] b, input bit last);
    int unsigned     c;
    int unsigned     p;
    longint unsigned rng;
    longint unsigned mid;
    bit              bv;
    c = 1;
    for (int k = 0; k < 8; k++) begin
      bv  = b[7-k];
      p   = mp[c];
      rng = (mx2[k] - mx1[k]) / 4096;
      mid = (mx1[k] + rng * p) % MOD;
      if (bv) mx2[k] = mid;
      else    mx1[k] = mid + 1;
      if (bv) mp[c] = p + (4096 - p) / 16;
      else    mp[c] = p - p / 16;
      while (mx1[k] / TOP == mx2[k] / TOP) begin
        exp_q.push_back(pk(k, mx2[k] / TOP, 1'b0));
        mx1[k] = (mx1[k] * 256) % MOD;
        mx2[k] = (mx2[k] * 256) % MOD + 255;
      end
      c = 2 * c + bv;
    end
    if (last)
      for (int k = 0; k < 8; k++)
        exp_q.push_back(pk(k, mx1[k] / TOP, k == 7));
  endtask

  task automatic add_byte(input logic [7:0] b, input bit l,
                          input bit use_model);
    stim_b.push_back(b);
    stim_l.push_back(l);
    if (use_model) model_byte(b, l);
  endtask

  task automatic const_flush(input logic [7:0] b);
    for (int k = 0; k < 8; k++)
      exp_q.push_back(pk(k, 64'(b), k == 7));
  endtask

  task automatic drive_in();
    if (stim_b.size() > 0) begin
      model_in_valid     = 1'b1;
      model_in_bits_byte = stim_b[0];
      model_in_bits_last = stim_l[0];
    end else begin
      model_in_valid     = 1'b0;
      model_in_bits_byte = 8'd0;
      model_in_bits_last = 1'b0;
    end
  endtask

  task automatic set_ready(input int mode, input bit first);
    case (mode)
      0: coder_out_ready = 1'b1;
      1: coder_out_ready = first ? 1'b1 : ~coder_out_ready;
      default: coder_out_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic do_reset(input bit check);
    model_rst       = 1'b1;
    model_in_valid  = 1'b0;
    coder_out_ready = 1'b1;
    stim_b.delete();
    stim_l.delete();
    exp_q.delete();
    tick();
    tick();
    chk("rst_outputs", 32'(out_vec()), 32'd0);
    model_rst = 1'b0;
    for (int n = 1; n <= 256; n++) begin
      tick();
      if (check && n < 256)
        chk("init_quiet", 32'(out_vec()), 32'd0);
    end
    chk("init_done", 32'({model_status_initDone, model_in_ready}),
        32'd3);
    model_reset();
  endtask

  task automatic run_stream(input int mode, input bit ends);
    bit          acc;
    bit          stalled;
    bit          done;
    logic [16:0] held;
    logic [16:0] o;
    stalled = 1'b0;
    done    = 1'b0;
    held    = '0;
    acc_cyc.delete();
    obs_q.delete();
    drive_in();
    set_ready(mode, 1'b1);
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      o = {coder_out_bits_idx, coder_out_bits_byte,
           coder_out_bits_last};
      if (stalled)
        chk("stall_hold", 32'({coder_out_valid, o}),
            32'({1'b1, held}));
      acc = model_in_valid && model_in_ready;
      if (acc) acc_cyc.push_back(cyc);
      if (coder_out_valid && coder_out_ready) begin
        obs_q.push_back(o);
        if (exp_q.size() > 0)
          chk("out_byte", 32'(o), 32'(exp_q.pop_front()));
        else
          chk("extra_out", 32'(o), 32'h1FFFF);
      end
      stalled = coder_out_valid && !coder_out_ready;
      held    = o;
      tick();
      if (acc) begin
        stim_b.delete(0);
        stim_l.delete(0);
      end
      drive_in();
      set_ready(mode, 1'b0);
      done = (stim_b.size() == 0) && (exp_q.size() == 0);
    end
    chk("drain", 32'(exp_q.size() + stim_b.size()), 32'd0);
    coder_out_ready = 1'b1;
    repeat (12) tick();
    chk("quiet_after", 32'({coder_out_valid, model_in_ready}),
        32'({1'b0, !ends}));
  endtask

  initial begin
    // reset release and INIT timing
    do_reset(1'b1);

    // all-zero byte: every coder flushes 0x7F
    add_byte(8'h00, 1'b1, 1'b0);
    const_flush(8'h7F);
    run_stream(0, 1'b1);
    chk("done_ignores", 32'(model_in_ready), 32'd0);

    // all-one byte: every coder flushes 0x00
    do_reset(1'b0);
    add_byte(8'hFF, 1'b1, 1'b0);
    const_flush(8'h00);
    run_stream(0, 1'b1);

    // second zero byte codes with adapted p=1920
    do_reset(1'b0);
    add_byte(8'h00, 1'b0, 1'b0);
    add_byte(8'h00, 1'b1, 1'b0);
    const_flush(8'hBB);
    run_stream(0, 1'b1);
    chk("accepts", 32'(acc_cyc.size()), 32'd2);
    if (acc_cyc.size() == 2)
      chk("byte_interval", 32'(acc_cyc[1] - acc_cyc[0]), 32'd9);

    // long zero run, ready high, then ready toggling
    do_reset(1'b0);
    for (int i = 0; i < 48; i++) add_byte(8'h00, i == 47, 1'b1);
    run_stream(0, 1'b1);
    ref_q = obs_q;
    do_reset(1'b0);
    for (int i = 0; i < 48; i++) add_byte(8'h00, i == 47, 1'b1);
    run_stream(1, 1'b1);
    chk("bp_len", 32'(obs_q.size()), 32'(ref_q.size()));
    for (int i = 0; i < obs_q.size() && i < ref_q.size(); i++)
      chk("bp_same", 32'(obs_q[i]), 32'(ref_q[i]));

    // random bytes with random backpressure
    do_reset(1'b0);
    for (int i = 0; i < 40; i++)
      add_byte(8'($urandom), i == 39, 1'b1);
    run_stream(2, 1'b1);

    // random bytes without last, ready high
    do_reset(1'b0);
    for (int i = 0; i < 30; i++)
      add_byte(8'($urandom), 1'b0, 1'b1);
    run_stream(0, 1'b0);

    // reset while stalled in SHIFT
    do_reset(1'b0);
    coder_out_ready    = 1'b0;
    model_in_valid     = 1'b1;
    model_in_bits_byte = 8'h00;
    model_in_bits_last = 1'b0;
    for (int c = 0; c < 3000 && !coder_out_valid; c++) tick();
    chk("shift_seen", 32'({coder_out_valid, coder_out_bits_last}),
        32'd2);
    model_rst      = 1'b1;
    model_in_valid = 1'b0;
    tick();
    chk("rst_mid", 32'(out_vec()), 32'd0);
    do_reset(1'b1);
    add_byte(8'h00, 1'b1, 1'b0);
    const_flush(8'h7F);
    run_stream(0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
